// File: rtl/register_hazard_unit_pkg.sv
// Shared core parameters for the RAW-hazard scoreboard and its sub-module.
package register_hazard_unit_pkg;
  localparam int XLEN                 = 32;
  localparam int REG_ADDR_WIDTH       = 5;
  localparam int HAZARD_DEPTH_DEFAULT = 2;
endpackage

// File: rtl/hazard_match_select.sv
// Per-source operand resolution: youngest matching in-flight entry wins,
// then either forwards its ready result or requests a stall.
module hazard_match_select #(
  parameter int XLEN           = register_hazard_unit_pkg::XLEN,
  parameter int REG_ADDR_WIDTH = register_hazard_unit_pkg::REG_ADDR_WIDTH,
  parameter int DEPTH          = register_hazard_unit_pkg::HAZARD_DEPTH_DEFAULT,
  parameter bit FORWARD_EN     = 1'b1
) (
  input  logic [REG_ADDR_WIDTH-1:0]       i_Rs,
  input  logic                            i_Rs_Used,
  input  logic [DEPTH-1:0]                i_Entry_Valid,
  input  logic [DEPTH*REG_ADDR_WIDTH-1:0] i_Entry_Rd,
  input  logic [DEPTH*XLEN-1:0]           i_Stage_Result,
  input  logic [DEPTH-1:0]                i_Stage_Ready,
  output logic                            o_Stall_Req,
  output logic                            o_Fwd_Valid,
  output logic [XLEN-1:0]                 o_Fwd_Data
);

  logic            hit;
  logic            hit_ready;
  logic [XLEN-1:0] hit_data;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hit         = 1'b0;
    hit_ready   = 1'b0;
    hit_data    = '0;
    o_Stall_Req = 1'b0;
    o_Fwd_Valid = 1'b0;
    o_Fwd_Data  = '0;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    if (i_Rs_Used && (i_Rs != '0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (i_Entry_Valid[k] && (i_Entry_Rd[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == i_Rs)) begin
          hit       = 1'b1;
          hit_ready = i_Stage_Ready[k];
          hit_data  = i_Stage_Result[k*XLEN +: XLEN];
        end
      end
    end

    o_Fwd_Valid = FORWARD_EN && hit && hit_ready;
    o_Stall_Req = hit && !(FORWARD_EN && hit_ready);
    o_Fwd_Data  = o_Fwd_Valid ? hit_data : '0;
  end

endmodule

// File: rtl/register_hazard_unit.sv
// RAW-hazard scoreboard for the in-order core: tracks destination registers of
// DEPTH post-issue stages and forwards ready results or stalls issue.
module register_hazard_unit #(
  parameter int XLEN           = register_hazard_unit_pkg::XLEN,
  parameter int REG_ADDR_WIDTH = register_hazard_unit_pkg::REG_ADDR_WIDTH,
  parameter int DEPTH          = register_hazard_unit_pkg::HAZARD_DEPTH_DEFAULT,
  parameter bit FORWARD_EN     = 1'b1
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Issue_Valid,
  input  logic [REG_ADDR_WIDTH-1:0]    i_Issue_Rd,
  input  logic                         i_Issue_Rd_Write_En,
  input  logic [REG_ADDR_WIDTH-1:0]    i_Rs_1,
  input  logic [REG_ADDR_WIDTH-1:0]    i_Rs_2,
  input  logic                         i_Rs_1_Used,
  input  logic                         i_Rs_2_Used,
  input  logic                         i_Advance,
  input  logic                         i_Flush,
  input  logic [DEPTH*XLEN-1:0]        i_Stage_Result,
  input  logic [DEPTH-1:0]             i_Stage_Ready,
  output logic                         o_Stall,
  output logic                         o_Fwd_1_Valid,
  output logic [XLEN-1:0]              o_Fwd_1_Data,
  output logic                         o_Fwd_2_Valid,
  output logic [XLEN-1:0]              o_Fwd_2_Data,
  output logic [$clog2(DEPTH+1)-1:0]   o_Inflight_Count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]                entry_valid;
  logic [DEPTH*REG_ADDR_WIDTH-1:0] entry_rd;
  logic                            stall_1;
  logic                            stall_2;
  logic                            issue_record;

  hazard_match_select #(
    .XLEN(XLEN), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .DEPTH(DEPTH), .FORWARD_EN(FORWARD_EN)
  ) u_src_1 (
    .i_Rs(i_Rs_1), .i_Rs_Used(i_Rs_1_Used),
    .i_Entry_Valid(entry_valid), .i_Entry_Rd(entry_rd),
    .i_Stage_Result(i_Stage_Result), .i_Stage_Ready(i_Stage_Ready),
    .o_Stall_Req(stall_1), .o_Fwd_Valid(o_Fwd_1_Valid), .o_Fwd_Data(o_Fwd_1_Data)
  );

  hazard_match_select #(
    .XLEN(XLEN), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .DEPTH(DEPTH), .FORWARD_EN(FORWARD_EN)
  ) u_src_2 (
    .i_Rs(i_Rs_2), .i_Rs_Used(i_Rs_2_Used),
    .i_Entry_Valid(entry_valid), .i_Entry_Rd(entry_rd),
    .i_Stage_Result(i_Stage_Result), .i_Stage_Ready(i_Stage_Ready),
    .o_Stall_Req(stall_2), .o_Fwd_Valid(o_Fwd_2_Valid), .o_Fwd_Data(o_Fwd_2_Data)
  );

  assign o_Stall      = i_Issue_Valid && (stall_1 || stall_2);
  // A stalled instruction enters as a bubble; x0 writes are never hazards.
  assign issue_record = i_Issue_Valid && i_Issue_Rd_Write_En && (i_Issue_Rd != '0) && !o_Stall;

  always_ff @(posedge i_Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (i_Reset || i_Flush) begin
      entry_valid <= '0;
    end else if (i_Advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        entry_valid[k] <= entry_valid[k-1];
      end
      entry_valid[0] <= issue_record;
    end
  end

  // NOTE: register indices carry no reset; they are qualified by entry_valid everywhere.
  always_ff @(posedge i_Clock) begin
    if (i_Advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        entry_rd[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] <= entry_rd[(k-1)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      end
      entry_rd[0 +: REG_ADDR_WIDTH] <= i_Issue_Rd;
    end
  end

  always_comb begin
    o_Inflight_Count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_Inflight_Count = o_Inflight_Count + CW'(entry_valid[k]);
    end
  end

endmodule
